// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with MOC handshake waits and a stalled-memory timeout.
module multicycle_sequencer #(
  parameter int unsigned MOC_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       moc,
  input  logic [5:0] opcode,
  output logic       irLoad,
  output logic       pcLoad,
  output logic       marLoad,
  output logic       mdrLoad,
  output logic       regWrite,
  output logic       rfSource,
  output logic       mdrSource,
  output logic       pcSelect,
  output logic [1:0] aluSource,
  output logic       immediate,
  output logic [5:0] aluCode,
  output logic       branch,
  output logic       jump,
  output logic       rw,
  output logic       fault,
  output logic       illegalOp,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MOC_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, FETCH_ADDR, FETCH_MEM, FETCH_IR, DECODE, EXEC_R, EXEC_I, MEM_ADDR,
    MEM_RD, LOAD_MDR, WB_MEM, MEM_WR, BRANCH, JUMP, FAULT
  } stateT;

  stateT curState, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic inWait, timedOut;

  logic irLoadD, pcLoadD, marLoadD, mdrLoadD, regWriteD, rfSourceD, mdrSourceD, pcSelectD;
  logic [1:0] aluSourceD;
  logic immediateD;
  logic [5:0] aluCodeD;
  logic branchD, jumpD, rwD, faultD;

  assign inWait   = (curState == FETCH_MEM) || (curState == MEM_RD) || (curState == MEM_WR);
  assign timedOut = (waitCnt >= TIMEOUT_CNT);
  assign state    = curState;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curState <= IDLE;
    else        curState <= nextState;
  end

  // Next-state logic; illegalOp is the only opcode-dependent output
  always_comb begin
    nextState = curState;
    illegalOp = 1'b0;
    case (curState)
      IDLE:       nextState = FETCH_ADDR;
      FETCH_ADDR: nextState = FETCH_MEM;
      FETCH_MEM:  if (moc) nextState = FETCH_IR; else if (timedOut) nextState = FAULT;
      FETCH_IR:   nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nextState = EXEC_R;
          OP_ADDI:      nextState = EXEC_I;
          OP_LW, OP_SW: nextState = MEM_ADDR;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default: begin
            nextState = FETCH_ADDR;
            illegalOp = 1'b1;
          end
        endcase
      end
      EXEC_R, EXEC_I, WB_MEM, BRANCH, JUMP: nextState = FETCH_ADDR;
      MEM_ADDR: begin
        if (opcode == OP_LW)      nextState = MEM_RD;
        else if (opcode == OP_SW) nextState = MEM_WR;
        else                      nextState = FETCH_ADDR;
      end
      MEM_RD:   if (moc) nextState = LOAD_MDR;   else if (timedOut) nextState = FAULT;
      LOAD_MDR: nextState = WB_MEM;
      MEM_WR:   if (moc) nextState = FETCH_ADDR; else if (timedOut) nextState = FAULT;
      FAULT:    nextState = FAULT;
      default:  nextState = IDLE;
    endcase
  end

  // Moore output decode of the upcoming state, registered below
  always_comb begin
    irLoadD = 1'b0; pcLoadD = 1'b0; marLoadD = 1'b0; mdrLoadD = 1'b0;
    regWriteD = 1'b0; rfSourceD = 1'b0; mdrSourceD = 1'b0; pcSelectD = 1'b0;
    aluSourceD = 2'b00; immediateD = 1'b0; aluCodeD = 6'd0;
    branchD = 1'b0; jumpD = 1'b0; rwD = 1'b1; faultD = 1'b0;
    case (nextState)
      FETCH_ADDR: begin
        aluSourceD = 2'b11; immediateD = 1'b1; aluCodeD = ALU_ADD; marLoadD = 1'b1;
      end
      FETCH_IR: begin
        irLoadD = 1'b1; pcLoadD = 1'b1;
      end
      EXEC_R: begin
        pcSelectD = 1'b1; rfSourceD = 1'b1; regWriteD = 1'b1;
      end
      EXEC_I: begin
        pcSelectD = 1'b1; aluSourceD = 2'b01; immediateD = 1'b1; aluCodeD = ALU_ADD;
        regWriteD = 1'b1;
      end
      MEM_ADDR: begin
        pcSelectD = 1'b1; aluSourceD = 2'b01; immediateD = 1'b1; aluCodeD = ALU_ADD;
        marLoadD = 1'b1;
      end
      LOAD_MDR: mdrLoadD = 1'b1;
      WB_MEM: begin
        mdrSourceD = 1'b1; regWriteD = 1'b1;
      end
      MEM_WR: rwD = 1'b0;
      BRANCH: begin
        pcSelectD = 1'b1; immediateD = 1'b1; aluCodeD = ALU_SUB; branchD = 1'b1;
        pcLoadD = 1'b1;
      end
      JUMP: begin
        jumpD = 1'b1; pcLoadD = 1'b1;
      end
      FAULT:   faultD = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irLoad <= 1'b0; pcLoad <= 1'b0; marLoad <= 1'b0; mdrLoad <= 1'b0;
      regWrite <= 1'b0; rfSource <= 1'b0; mdrSource <= 1'b0; pcSelect <= 1'b0;
      aluSource <= 2'b00; immediate <= 1'b0; aluCode <= 6'd0;
      branch <= 1'b0; jump <= 1'b0; rw <= 1'b1; fault <= 1'b0;
    end else begin
      irLoad <= irLoadD; pcLoad <= pcLoadD; marLoad <= marLoadD; mdrLoad <= mdrLoadD;
      regWrite <= regWriteD; rfSource <= rfSourceD; mdrSource <= mdrSourceD;
      pcSelect <= pcSelectD; aluSource <= aluSourceD; immediate <= immediateD;
      aluCode <= aluCodeD; branch <= branchD; jump <= jumpD; rw <= rwD; fault <= faultD;
    end
  end

  // Wait counter: cleared whenever not sitting in a wait state with moc low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (inWait && !moc && (nextState == curState)) begin
      if (waitCnt != CNT_MAX) waitCnt <= waitCnt + CNT_W'(1);
    end else begin
      waitCnt <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a per-instruction phase model queues the
// expected state/outputs of every cycle; a negedge monitor compares the DUT against them.
module tb_multicycle_sequencer;

  localparam int TIMEOUT = 15;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_FA = 4'd1, ST_FM = 4'd2, ST_FI = 4'd3,
                         ST_DEC = 4'd4, ST_ER = 4'd5, ST_EI = 4'd6, ST_MA = 4'd7,
                         ST_MRD = 4'd8, ST_LMDR = 4'd9, ST_WB = 4'd10, ST_MWR = 4'd11,
                         ST_BR = 4'd12, ST_JMP = 4'd13, ST_FAULT = 4'd14;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         ALU_ADD = 6'b100000, ALU_SUB = 6'b100010;

  typedef struct packed {
    logic [3:0] st;
    logic irLoad, pcLoad, marLoad, mdrLoad, regWrite, rfSource, mdrSource, pcSelect;
    logic [1:0] aluSource;
    logic immediate;
    logic [5:0] aluCode;
    logic branch, jump, rw, fault, illegalOp;
  } obsT;

  typedef struct packed {
    logic rstN;
    logic moc;
    logic [5:0] op;
  } stimT;

  logic clk = 1'b0, reset = 1'b1, moc = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic irLoad, pcLoad, marLoad, mdrLoad, regWrite, rfSource, mdrSource, pcSelect;
  logic [1:0] aluSource;
  logic immediate;
  logic [5:0] aluCode;
  logic branch, jump, rw, fault, illegalOp;
  logic [3:0] state;

  obsT  expQ[$];
  stimT stimQ[$];
  int nChecks = 0, nPass = 0, cycleNo = 0;
  bit running = 1'b0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MOC_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .moc(moc), .opcode(opcode),
    .irLoad(irLoad), .pcLoad(pcLoad), .marLoad(marLoad), .mdrLoad(mdrLoad),
    .regWrite(regWrite), .rfSource(rfSource), .mdrSource(mdrSource), .pcSelect(pcSelect),
    .aluSource(aluSource), .immediate(immediate), .aluCode(aluCode),
    .branch(branch), .jump(jump), .rw(rw), .fault(fault), .illegalOp(illegalOp),
    .state(state)
  );

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  // Control word each state must present
  function automatic obsT expectFor(input logic [3:0] st, input logic ill);
    obsT o;
    o = '0;
    o.st = st;
    o.rw = 1'b1;
    case (st)
      ST_FA:   begin o.aluSource = 2'b11; o.immediate = 1'b1; o.aluCode = ALU_ADD; o.marLoad = 1'b1; end
      ST_FI:   begin o.irLoad = 1'b1; o.pcLoad = 1'b1; end
      ST_DEC:  o.illegalOp = ill;
      ST_ER:   begin o.pcSelect = 1'b1; o.rfSource = 1'b1; o.regWrite = 1'b1; end
      ST_EI:   begin o.pcSelect = 1'b1; o.aluSource = 2'b01; o.immediate = 1'b1;
                     o.aluCode = ALU_ADD; o.regWrite = 1'b1; end
      ST_MA:   begin o.pcSelect = 1'b1; o.aluSource = 2'b01; o.immediate = 1'b1;
                     o.aluCode = ALU_ADD; o.marLoad = 1'b1; end
      ST_LMDR: o.mdrLoad = 1'b1;
      ST_WB:   begin o.mdrSource = 1'b1; o.regWrite = 1'b1; end
      ST_MWR:  o.rw = 1'b0;
      ST_BR:   begin o.pcSelect = 1'b1; o.immediate = 1'b1; o.aluCode = ALU_SUB;
                     o.branch = 1'b1; o.pcLoad = 1'b1; end
      ST_JMP:  begin o.jump = 1'b1; o.pcLoad = 1'b1; end
      ST_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic pushCycle(input logic rstN, input logic m, input logic [5:0] op,
                           input logic [3:0] st, input logic ill);
    stimT s;
    s.rstN = rstN; s.moc = m; s.op = op;
    stimQ.push_back(s);
    expQ.push_back(rstN ? expectFor(st, ill) : expectFor(ST_IDLE, 1'b0));
  endtask

  // n cycles with moc low, then moc high; beyond the timeout the state faults instead
  task automatic waitPhase(input logic [3:0] st, input int n, input logic [5:0] op,
                           input bit randOp, output bit faulted);
    faulted = (n > TIMEOUT);
    for (int i = 0; i < (faulted ? TIMEOUT + 1 : n); i++)
      pushCycle(1'b1, 1'b0, randOp ? rnd6() : op, st, 1'b0);
    if (!faulted) pushCycle(1'b1, 1'b1, randOp ? rnd6() : op, st, 1'b0);
  endtask

  task automatic issueInstr(input logic [5:0] op, input int wf, input int wm, output bit faulted);
    bit legal;
    legal = op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    pushCycle(1'b1, 1'($urandom), rnd6(), ST_FA, 1'b0);
    waitPhase(ST_FM, wf, op, 1'b1, faulted);
    if (!faulted) begin
      pushCycle(1'b1, 1'($urandom), rnd6(), ST_FI, 1'b0);
      pushCycle(1'b1, 1'($urandom), op, ST_DEC, !legal);
      case (op)
        OP_R:    pushCycle(1'b1, 1'($urandom), op, ST_ER, 1'b0);
        OP_ADDI: pushCycle(1'b1, 1'($urandom), op, ST_EI, 1'b0);
        OP_BEQ:  pushCycle(1'b1, 1'($urandom), op, ST_BR, 1'b0);
        OP_J:    pushCycle(1'b1, 1'($urandom), op, ST_JMP, 1'b0);
        OP_LW: begin
          pushCycle(1'b1, 1'($urandom), op, ST_MA, 1'b0);
          waitPhase(ST_MRD, wm, op, 1'b0, faulted);
          if (!faulted) begin
            pushCycle(1'b1, 1'($urandom), op, ST_LMDR, 1'b0);
            pushCycle(1'b1, 1'($urandom), op, ST_WB, 1'b0);
          end
        end
        OP_SW: begin
          pushCycle(1'b1, 1'($urandom), op, ST_MA, 1'b0);
          waitPhase(ST_MWR, wm, op, 1'b0, faulted);
        end
        default: ;
      endcase
    end
  endtask

  task automatic resetSeq(input int n);
    for (int i = 0; i < n; i++) pushCycle(1'b0, 1'($urandom), rnd6(), ST_IDLE, 1'b0);
    pushCycle(1'b1, 1'b1, rnd6(), ST_IDLE, 1'b0);
  endtask

  task automatic faultHold(input int n);
    for (int i = 0; i < n; i++) pushCycle(1'b1, 1'(i), rnd6(), ST_FAULT, 1'b0);
  endtask

  // Monitor: one scoreboard comparison per cycle
  always @(negedge clk) begin
    if (running && expQ.size() > 0) begin
      obsT e, a;
      e = expQ.pop_front();
      a = {state, irLoad, pcLoad, marLoad, mdrLoad, regWrite, rfSource, mdrSource, pcSelect,
           aluSource, immediate, aluCode, branch, jump, rw, fault, illegalOp};
      nChecks++;
      if (a === e) nPass++;
      else $display("FAIL cycle %0d ctrl: act state=%0d word=%h, exp state=%0d word=%h",
                    cycleNo, a.st, a, e.st, e);
      cycleNo++;
    end
  end

  initial begin
    bit f;
    logic [5:0] op;
    stimT s;
    logic [5:0] opTab [6];
    opTab[0] = OP_R; opTab[1] = OP_ADDI; opTab[2] = OP_LW;
    opTab[3] = OP_SW; opTab[4] = OP_BEQ; opTab[5] = OP_J;

    resetSeq(3);
    issueInstr(OP_R, 0, 0, f);
    issueInstr(OP_LW, 3, 3, f);
    issueInstr(OP_SW, 0, 0, f);
    issueInstr(OP_BEQ, 0, 0, f);
    issueInstr(OP_J, 0, 0, f);
    issueInstr(OP_ADDI, 1, 0, f);
    issueInstr(6'b111111, 0, 0, f);
    issueInstr(OP_R, 15, 0, f);
    issueInstr(OP_SW, 0, 15, f);
    issueInstr(OP_LW, 10, 15, f);
    issueInstr(OP_R, 16, 0, f);
    faultHold(6); resetSeq(2);
    issueInstr(OP_LW, 0, 16, f);
    faultHold(2); resetSeq(1);
    issueInstr(OP_SW, 2, 16, f);
    faultHold(2); resetSeq(1);
    // Store abandoned by reset while waiting in MEM_WR
    pushCycle(1'b1, 1'b1, rnd6(), ST_FA, 1'b0);
    pushCycle(1'b1, 1'b1, rnd6(), ST_FM, 1'b0);
    pushCycle(1'b1, 1'b0, rnd6(), ST_FI, 1'b0);
    pushCycle(1'b1, 1'b0, OP_SW, ST_DEC, 1'b0);
    pushCycle(1'b1, 1'b1, OP_SW, ST_MA, 1'b0);
    for (int i = 0; i < 3; i++) pushCycle(1'b1, 1'b0, OP_SW, ST_MWR, 1'b0);
    resetSeq(1);
    issueInstr(OP_R, 0, 0, f);
    for (int k = 0; k < 40; k++) begin
      int sel, wf, wm;
      sel = int'($urandom_range(0, 6));
      op  = (sel == 6) ? rnd6() : opTab[sel];
      wf  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 16)) : int'($urandom_range(0, 3));
      wm  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 16)) : int'($urandom_range(0, 3));
      issueInstr(op, wf, wm, f);
      if (f) begin
        faultHold(3);
        resetSeq(1);
      end
    end

    #2 reset = 1'b0;
    @(posedge clk); #1;
    running = 1'b1;
    while (stimQ.size() > 0) begin
      s = stimQ.pop_front();
      reset = s.rstN; moc = s.moc; opcode = s.op;
      @(posedge clk); #1;
    end
    running = 1'b0;
    nChecks++;
    if (expQ.size() == 0) nPass++;
    else $display("FAIL drain: act pending=%0d, exp pending=0", expQ.size());
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Control FSM for the multicycle MIPS datapath (PC, MAR/MDR, IR, register file, ALU, handshaken memory). Steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath load, select and ALU control line. Waits on the memory MOC handshake and detects stalled memory via a timeout. Handles R-type, addi, lw, sw, beq and j.

Parameters:
MOC_TIMEOUT, 15, max cycles spent in any MOC wait state before entering FAULT.
CNT_W, 4, width of the wait counter; must hold MOC_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
moc  in  1  memory operation complete.
opcode  in  6  IR[31:26].
irLoad  out  1  IR load enable.
pcLoad  out  1  PC load enable.
marLoad  out  1  MAR load enable (from ALU out).
mdrLoad  out  1  MDR load enable.
regWrite  out  1  register-file write enable.
rfSource  out  1  destination register select: 0=rt, 1=rd.
mdrSource  out  1  RF write data select: 0=ALU, 1=memory/MDR.
pcSelect  out  1  ALU A select: 0=PC, 1=rs.
aluSource  out  2  ALU B select: 00=rt, 01=signext, 10=MDR, 11=zero.
immediate  out  1  1=ALU op from aluCode; 0=ALU op from funct.
aluCode  out  6  ALU op: ADD=6'b100000, SUB=6'b100010, else 0.
branch  out  1  branch qualifier, ANDed with zero flag.
jump  out  1  PC next = jump target.
rw  out  1  memory direction: 1=read, 0=write.
fault  out  1  sticky memory-timeout flag.
illegalOp  out  1  one-cycle pulse on an unsupported opcode.
state  out  4  current state, for debug.

Behaviour:
- Moore outputs decoded from the registered state. Only illegalOp depends on opcode in DECODE.
- Listed signals are 1. All others are 0. rw defaults to 1.
- Reset (async, low): state=IDLE. All outputs 0 except rw=1. Wait counter=0. fault=0.
- IDLE: no asserts. Next state FETCH_ADDR.
- FETCH_ADDR: pcSelect=0, aluSource=11, immediate=1, aluCode=ADD, marLoad. Next state FETCH_MEM.
- FETCH_MEM: rw=1. Stays while moc=0; on moc=1 goes to FETCH_IR.
- FETCH_IR: irLoad, pcLoad. jump=0 and branch=0, so PC<=PC+4. Next state DECODE.
- DECODE: no loads. Dispatch on opcode:
  - 000000 -> EXEC_R
  - 001000 -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode: illegalOp=1 this cycle, then FETCH_ADDR (treated as NOP).
- EXEC_R: pcSelect=1, aluSource=00, immediate=0, rfSource=1, mdrSource=0, regWrite. Next state FETCH_ADDR.
- EXEC_I: pcSelect=1, aluSource=01, immediate=1, aluCode=ADD, rfSource=0, mdrSource=0, regWrite. Next state FETCH_ADDR.
- MEM_ADDR: pcSelect=1, aluSource=01, immediate=1, aluCode=ADD, marLoad. lw -> MEM_RD; sw -> MEM_WR. Uses the opcode latched in IR.
- MEM_RD: rw=1. Waits on moc, then LOAD_MDR.
- LOAD_MDR: rw=1, mdrLoad. Next state WB_MEM.
- WB_MEM: rfSource=0, mdrSource=1, regWrite. Next state FETCH_ADDR.
- MEM_WR: rw=0. Waits on moc, then FETCH_ADDR.
- BRANCH: pcSelect=1, aluSource=00, immediate=1, aluCode=SUB, branch, pcLoad. Next state FETCH_ADDR.
- JUMP: jump, pcLoad. Next state FETCH_ADDR.
- FAULT: all outputs idle (rw=1), fault=1. Held until reset.
- Wait counter:
  - Clears on entry to each wait state (FETCH_MEM, MEM_RD, MEM_WR).
  - Increments each cycle moc=0 in a wait state.
  - Saturates at 2^CNT_W-1.
  - Wait cycle MOC_TIMEOUT+1 with moc still 0 -> FAULT.
  - moc=1 on the timeout cycle: moc wins, normal transition, no fault.
- moc=1 in a non-wait state is ignored.
- Reset asserted mid-instruction: immediate return to IDLE. Partial loads are abandoned. No further writes occur.
- Cycle counts with moc=1 on the first wait cycle:
  - R-type, addi, beq, j: 5 cycles.
  - sw: 6 cycles.
  - lw: 8 cycles.
  - Each extra moc wait cycle adds 1.

Test Plan:
- Reset low for 3 cycles, then release with moc tied to 1 and opcode=000000 -> state IDLE, FETCH_ADDR, FETCH_MEM, FETCH_IR, DECODE, EXEC_R, FETCH_ADDR. regWrite=1 and rfSource=1 only in EXEC_R. pcLoad=1 only in FETCH_IR.
- opcode=100011, moc delayed 3 cycles in both FETCH_MEM and MEM_RD -> 14-cycle instruction. mdrLoad=1 exactly once, in LOAD_MDR. Then regWrite=1 with mdrSource=1.
- opcode=101011 -> rw=0 only in MEM_WR and no regWrite pulse. opcode=000100 -> branch=1, aluCode=6'b100010, pcLoad=1 in one cycle.
- opcode=111111 -> illegalOp pulses high for 1 cycle in DECODE, then FETCH_ADDR with no regWrite, pcLoad or marLoad in between.
- moc held 0 in FETCH_MEM with MOC_TIMEOUT=15 -> FAULT entered after 16 wait cycles. fault stays 1 with moc toggling, until reset drops low.
- Reset dropped asynchronously mid-clock during MEM_WR -> outputs go to reset values (rw=1) before the next edge and state=IDLE.
